// File: rtl/pipelined_ripple_adder.sv
// -----------------------------------------------------------------------------
// pipelined_ripple_adder
//
// Purpose:
//   WIDTH-bit adder whose carry chain is cut into STAGES equal segments of
//   SEG = WIDTH/STAGES bits, with one register stage per segment. Stage k adds
//   segment k of the operands plus the carry registered by stage k-1, so the
//   critical path is a single SEG-bit ripple. One operation per cycle is
//   accepted; results appear STAGES enabled edges later, fully aligned.
//   A valid/ready handshake with a single global advance enable provides
//   backpressure: when the output is occupied and not taken, everything holds.
//
// Optional feature (macro ADDER_SUB_EN):
//   Adds the SubMode input. SubMode travels with its operation; in subtract
//   mode each stage uses the inverted B segment and stage 0 forces carry-in
//   to 1 (CarryIn ignored), giving A - B. CarryOut=1 then means "no borrow".
//   Without the macro the port and its pipeline bits do not exist.
//
// Ports:
//   Clk       in   1      rising-edge clock
//   Rst       in   1      synchronous active-high reset, priority over all
//   InputA    in   WIDTH  operand A
//   InputB    in   WIDTH  operand B
//   CarryIn   in   1      carry into bit 0
//   SubMode   in   1      (ADDER_SUB_EN only) 1 = subtract
//   InValid   in   1      operands valid this cycle
//   InReady   out  1      block accepts this cycle (= !OutValid || OutReady)
//   OutSum    out  WIDTH  registered sum
//   CarryOut  out  1      carry out of bit WIDTH-1
//   Overflow  out  1      two's-complement signed overflow
//   OutValid  out  1      result outputs valid
//   OutReady  in   1      downstream accepts this cycle
// -----------------------------------------------------------------------------
module pipelined_ripple_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic             CarryIn,
`ifdef ADDER_SUB_EN
   input  logic             SubMode,
`endif
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] OutSum,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             OutValid,
   input  logic             OutReady
);

   localparam int SEG = WIDTH / STAGES;

   // Single global enable: the whole pipe moves only when the output slot is
   // empty or being drained this cycle.
   logic adv;
   assign adv     = !OutValid || OutReady;
   assign InReady = adv;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // Bits below LO are already summed when an operation reaches this stage.
         localparam int LO = gi * SEG;

         // src_w packs {pending A bits, completed sum bits} into one word; this
         // stage replaces its own segment of A with the segment sum.
         logic [WIDTH-1:0]    src_w;
         // Remaining (not yet consumed) B bits; bit 0 is this stage's segment.
         logic [WIDTH-LO-1:0] src_b;
         logic                src_c;
         logic                src_v;
`ifdef ADDER_SUB_EN
         logic                src_sub;
`endif
         logic [SEG-1:0]      seg_b;
         logic [SEG:0]        seg_res;
         logic [WIDTH-1:0]    w_d;

         logic                vld_q;
         logic [WIDTH-1:0]    w_q;
         logic                cy_q;

         if (gi == 0) begin : g_src
            assign src_w = InputA;
            assign src_b = InputB;
            assign src_v = InValid;
`ifdef ADDER_SUB_EN
            assign src_sub = SubMode;
            // Subtract forces the +1 of the two's-complement negation.
            assign src_c   = SubMode | CarryIn;
`else
            assign src_c   = CarryIn;
`endif
         end else begin : g_src
            assign src_w = g_stage[gi-1].w_q;
            assign src_b = g_stage[gi-1].g_pend.b_q;
            assign src_v = g_stage[gi-1].vld_q;
            assign src_c = g_stage[gi-1].cy_q;
`ifdef ADDER_SUB_EN
            assign src_sub = g_stage[gi-1].g_pend.sub_q;
`endif
         end

         always_comb begin
`ifdef ADDER_SUB_EN
            seg_b = src_b[SEG-1:0] ^ {SEG{src_sub}};
`else
            seg_b = src_b[SEG-1:0];
`endif
            seg_res = {1'b0, src_w[LO +: SEG]} + {1'b0, seg_b} + {{SEG{1'b0}}, src_c};
            w_d = src_w;
            w_d[LO +: SEG] = seg_res[SEG-1:0];
         end

         always_ff @(posedge Clk) begin
            if (Rst) begin
               vld_q <= 1'b0;
               w_q   <= '0;
               cy_q  <= 1'b0;
            end else if (adv) begin
               vld_q <= src_v;
               w_q   <= w_d;
               cy_q  <= seg_res[SEG];
            end
         end

         // Skew registers for the B bits (and the mode bit) still to be added
         // by later stages. The last stage has nothing left to carry forward.
         if (gi < STAGES - 1) begin : g_pend
            logic [WIDTH-LO-SEG-1:0] b_q;
`ifdef ADDER_SUB_EN
            logic                    sub_q;
`endif
            always_ff @(posedge Clk) begin
               if (Rst) begin
                  b_q <= '0;
`ifdef ADDER_SUB_EN
                  sub_q <= 1'b0;
`endif
               end else if (adv) begin
                  b_q <= src_b[WIDTH-LO-1:SEG];
`ifdef ADDER_SUB_EN
                  sub_q <= src_sub;
`endif
               end
            end
         end

         // The top segment sees the operand MSBs and the result MSB together,
         // so signed overflow is resolved here and registered with the sum.
         if (gi == STAGES - 1) begin : g_last
            logic ov_d;
            logic ov_q;

            always_comb begin
               ov_d = (src_w[WIDTH-1] == seg_b[SEG-1]) &&
                      (seg_res[SEG-1] != src_w[WIDTH-1]);
            end

            always_ff @(posedge Clk) begin
               if (Rst) begin
                  ov_q <= 1'b0;
               end else if (adv) begin
                  ov_q <= ov_d;
               end
            end
         end
      end
   endgenerate

   assign OutSum   = g_stage[STAGES-1].w_q;
   assign CarryOut = g_stage[STAGES-1].cy_q;
   assign Overflow = g_stage[STAGES-1].g_last.ov_q;
   assign OutValid = g_stage[STAGES-1].vld_q;

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined successor to the combinational ripple-carry adder. The WIDTH-bit carry chain is split into STAGES equal segments, with one register stage per segment. Operands and partial sums are skewed so the block accepts one operation per cycle at a shorter critical path. A valid/ready handshake with backpressure lets it sit between streaming producers and consumers in the datapath.

## Interface
- WIDTH, 16, operand/sum width in bits; must be an integer multiple of STAGES
- STAGES, 4, number of pipeline segments/register stages, 1..WIDTH; SEG = WIDTH/STAGES bits per segment
- Clk  input  1  single clock; all state updates on rising edge
- Rst  input  1  reset, synchronous, active-high
- InputA  input  WIDTH  operand A
- InputB  input  WIDTH  operand B
- CarryIn  input  1  carry into bit 0
- InValid  input  1  operands/CarryIn valid this cycle
- InReady  output  1  block can accept this cycle
- OutSum  output  WIDTH  registered sum
- CarryOut  output  1  carry out of bit WIDTH-1 (unsigned overflow)
- Overflow  output  1  two's-complement signed overflow
- OutValid  output  1  OutSum/CarryOut/Overflow valid
- OutReady  input  1  downstream accepts this cycle
- SubMode  input  1  present only with ADDER_SUB_EN; 1 = subtract

## Operation
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of the operands plus the carry registered by stage k-1. Stage 0 uses CarryIn.
- Operand bits for segments k>0 travel through k-deep skew registers. Completed low segments travel through de-skew registers. The whole result appears aligned in the output stage.
- Each stage holds a valid bit. Bubbles (InValid=0 on an enabled edge) propagate as valid=0.
- Global enable: Adv = !OutValid || OutReady. InReady = Adv. This is a combinational path from OutReady and OutValid.
- Transfer in: InValid && InReady on a rising edge. Transfer out: OutValid && OutReady on a rising edge.
- When Adv=0, every stage, including the output, holds its data and valid bit. Input is not accepted.
- Arithmetic is modulo 2^WIDTH: {CarryOut, OutSum} = A + B + CarryIn.
- Overflow = (A[W-1] == B'[W-1]) && (OutSum[W-1] != A[W-1]). B' is the effective B operand, inverted in subtract mode.
- Reset: all valid bits are 0, OutSum=0, CarryOut=0, Overflow=0, OutValid=0. InReady=1 in the cycle after reset is released, because OutValid=0.
- Rst asserted mid-operation discards every in-flight operation. No partial result is ever presented.
- Rst has priority over Adv and over a simultaneous input transfer.

## Timing
- Latency is STAGES enabled edges. An operation accepted on edge E shows OutValid=1 after edge E+STAGES-1, assuming no stall.
- With STAGES=1 the result is registered on the acceptance edge, i.e. one cycle of latency.
- Throughput is one operation per cycle while OutReady=1.
- A stall of N cycles adds exactly N cycles of latency to every in-flight operation. Order is preserved and no operation is lost or duplicated.
- Input transfer and output transfer on the same edge are legal and are the steady-state case.
- Critical path is one SEG-bit ripple segment plus the carry register setup.

## Configuration
- Macro: ADDER_SUB_EN.
- Defined:
  - SubMode port exists and travels with its operation through the pipeline.
  - When SubMode=1, stage logic uses ~InputB and forces carry-in to 1; CarryIn is ignored. Result is A - B.
  - CarryOut=1 means no borrow.
  - Overflow uses the inverted B MSB.
- Undefined:
  - SubMode port is absent; add only.
  - No extra registers are instantiated.

## Test plan
- WIDTH=16, STAGES=4: A=0xFFFF, B=0x0001, CarryIn=0 -> after 4 edges OutSum=0x0000, CarryOut=1, Overflow=0.
- A=0x7FFF, B=0x0001, CarryIn=1 -> OutSum=0x8001, CarryOut=0, Overflow=1. Also A=0x8000, B=0x8000 -> OutSum=0x0000, CarryOut=1, Overflow=1.
- Back-to-back stream of 8 random operations with OutReady=1 -> 8 consecutive OutValid cycles, results in order, first result 4 cycles after first accept.
- OutReady=0 for 3 cycles while pipeline full -> InReady=0, OutSum held stable. On release, results continue in order with none lost or duplicated.
- Reset asserted with 3 operations in flight -> next cycle OutValid=0, outputs 0, InReady=1. No stale results emerge afterwards.
- With ADDER_SUB_EN, SubMode=1: A=0x0005, B=0x0007 -> OutSum=0xFFFE, CarryOut=0. Repeat the first scenario at STAGES=1 and at WIDTH=8/STAGES=8 with latency 1 and 8 respectively.
